// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_ADDR,
      FETCH_RESP
   } fetch_state_t;

   localparam int FETCH_NENT  = 2;
   localparam int FETCH_IDX_W = 1;

   // Tags are kept in a separate ADDR_W-wide array so the entry type stays
   // independent of the address width parameter.
   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } fetch_ent_t;

endpackage

// File: rtl/fetch_unit_buf.sv
// rtl/fetch_unit_buf.sv - 2-entry address-tagged instruction store
// Ports: clk_i/reset_i; pc_i and pc_nxt_i (pc_i+4) select which tags are live;
// wr_en_i/wr_addr_i/wr_data_i write one word; hit_pc_o/hit_nxt_o report hits
// for pc_i and pc_i+4; data_o is the word at pc_i (zero on miss).
module fetch_unit_buf
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [ADDR_W-1:0] pc_nxt_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [31:0]       wr_data_i,
   output logic              hit_pc_o,
   output logic              hit_nxt_o,
   output logic [31:0]       data_o
);

   fetch_ent_t             ent [FETCH_NENT];
   logic [ADDR_W-1:0]      tag [FETCH_NENT];
   logic [FETCH_NENT-1:0]  keep;
   logic [FETCH_IDX_W-1:0] victim;
   logic                   found;
   logic                   wr_live;

   always_comb begin
      hit_pc_o  = 1'b0;
      hit_nxt_o = 1'b0;
      data_o    = '0;
      keep      = '0;
      for (int i = 0; i < FETCH_NENT; i++) begin
         keep[i] = ent[i].valid && (tag[i] == pc_i || tag[i] == pc_nxt_i);
         if (ent[i].valid && tag[i] == pc_i) begin
            hit_pc_o = 1'b1;
            data_o   = ent[i].data;
         end
         if (ent[i].valid && tag[i] == pc_nxt_i) begin
            hit_nxt_o = 1'b1;
         end
      end
   end

   // Victim priority: a live entry already holding this address (avoids a
   // duplicate tag), then any entry dropped this edge, then the one not at pc_i.
   always_comb begin
      victim = '0;
      found  = 1'b0;
      for (int i = 0; i < FETCH_NENT; i++) begin
         if (!found && keep[i] && tag[i] == wr_addr_i) begin
            victim = FETCH_IDX_W'(i);
            found  = 1'b1;
         end
      end
      for (int i = 0; i < FETCH_NENT; i++) begin
         if (!found && !keep[i]) begin
            victim = FETCH_IDX_W'(i);
            found  = 1'b1;
         end
      end
      for (int i = 0; i < FETCH_NENT; i++) begin
         if (!found && tag[i] != pc_i) begin
            victim = FETCH_IDX_W'(i);
            found  = 1'b1;
         end
      end
   end

   // Data for an address that is no longer pc_i/pc_i+4 is stale after a redirect.
   assign wr_live = wr_en_i && (wr_addr_i == pc_i || wr_addr_i == pc_nxt_i);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < FETCH_NENT; i++) begin
            ent[i] <= '0;
            tag[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FETCH_NENT; i++) begin
            ent[i].valid <= keep[i];
         end
         if (wr_live && found) begin
            ent[victim] <= '{valid: 1'b1, data: wr_data_i};
            tag[victim] <= wr_addr_i;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with 2-entry tagged buffer and next-word prefetch
// Ports: clk_i/reset_i; pc_i from ctl; inst_o/inst_valid_o word at pc_i;
// mem_req_o/mem_addr_o/mem_ready_i request channel; mem_rvalid_i/mem_rdata_i/
// mem_err_i response channel; fetch_fault_o sticky fault.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter bit PREFETCH_EN = 1'b1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [31:0]       inst_o,
   output logic              inst_valid_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ready_i,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_err_i,
   output logic              fetch_fault_o
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] fetch_addr;
   logic              have_fetch;
   logic              hit_pc;
   logic              hit_nxt;
   logic              misaligned;
   logic              wr_en;

   assign pc_nxt     = pc_i + ADDR_W'(4);
   assign misaligned = |pc_i[1:0];
   assign wr_en      = (state == FETCH_RESP) && mem_rvalid_i && !mem_err_i;
   assign mem_addr_o = req_addr;

   fetch_unit_buf #(.ADDR_W(ADDR_W)) u_buf (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .pc_i      (pc_i),
      .pc_nxt_i  (pc_nxt),
      .wr_en_i   (wr_en),
      .wr_addr_i (req_addr),
      .wr_data_i (mem_rdata_i),
      .hit_pc_o  (hit_pc),
      .hit_nxt_o (hit_nxt),
      .data_o    (inst_o)
   );

   assign inst_valid_o = hit_pc;

   always_comb begin
      have_fetch = 1'b0;
      fetch_addr = pc_i;
      if (!hit_pc) begin
         have_fetch = 1'b1;
      end else if (PREFETCH_EN && !hit_nxt) begin
         have_fetch = 1'b1;
         fetch_addr = pc_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state         <= FETCH_IDLE;
         req_addr      <= '0;
         mem_req_o     <= 1'b0;
         fetch_fault_o <= 1'b0;
      end else begin
         if (misaligned) begin
            fetch_fault_o <= 1'b1;
         end
         case (state)
            FETCH_IDLE: begin
               if (have_fetch && !fetch_fault_o && !misaligned) begin
                  req_addr  <= fetch_addr;
                  mem_req_o <= 1'b1;
                  state     <= FETCH_ADDR;
               end
            end
            FETCH_ADDR: begin
               if (mem_ready_i) begin
                  mem_req_o <= 1'b0;
                  state     <= FETCH_RESP;
               end
            end
            FETCH_RESP: begin
               if (mem_rvalid_i) begin
                  if (mem_err_i) begin
                     fetch_fault_o <= 1'b1;
                  end
                  state <= FETCH_IDLE;
               end
            end
            default: state <= FETCH_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with and without prefetch
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst_np;
   int          vecs  = 0;
   int          fails = 0;
   int          xfer_cnt = 0;
   int          xfer_base;

   // prefetching instance and its bus model
   logic [31:0] pc_pf;
   logic [31:0] inst_pf;
   logic        valid_pf, req_pf, fault_pf;
   logic [31:0] addr_pf;
   logic        ready_en, rv_q_pf, rv_inj, err_en;
   logic [31:0] raddr_pf, err_addr;
   logic        rvalid_pf, err_pf;
   logic [31:0] rdata_pf;

   // demand-only instance and its bus model
   logic [31:0] pc_np;
   logic [31:0] inst_np;
   logic        valid_np, req_np, fault_np;
   logic [31:0] addr_np;
   logic        rv_q_np;
   logic [31:0] raddr_np;
   logic [31:0] rdata_np;

   logic [31:0] exp_pf[$];
   logic [31:0] exp_np[$];

   always #5 clk = ~clk;

   assign rvalid_pf = rv_q_pf | rv_inj;
   assign rdata_pf  = raddr_pf + 32'd1;
   assign err_pf    = rvalid_pf && err_en && (raddr_pf == err_addr);
   assign rdata_np  = raddr_np + 32'd1;

   fetch_unit #(.ADDR_W(32), .PREFETCH_EN(1'b1)) u_pf (
      .clk_i(clk), .reset_i(rst), .pc_i(pc_pf), .inst_o(inst_pf), .inst_valid_o(valid_pf),
      .mem_req_o(req_pf), .mem_addr_o(addr_pf), .mem_ready_i(ready_en),
      .mem_rvalid_i(rvalid_pf), .mem_rdata_i(rdata_pf), .mem_err_i(err_pf),
      .fetch_fault_o(fault_pf)
   );

   fetch_unit #(.ADDR_W(32), .PREFETCH_EN(1'b0)) u_np (
      .clk_i(clk), .reset_i(rst_np), .pc_i(pc_np), .inst_o(inst_np), .inst_valid_o(valid_np),
      .mem_req_o(req_np), .mem_addr_o(addr_np), .mem_ready_i(1'b1),
      .mem_rvalid_i(rv_q_np), .mem_rdata_i(rdata_np), .mem_err_i(1'b0),
      .fetch_fault_o(fault_np)
   );

   // zero-wait memory: word at A is A+1, data one cycle after acceptance
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rv_q_pf  <= 1'b0;
         raddr_pf <= '0;
      end else begin
         rv_q_pf <= req_pf && ready_en;
         if (req_pf && ready_en) raddr_pf <= addr_pf;
      end
   end

   always @(posedge clk or posedge rst_np) begin
      if (rst_np) begin
         rv_q_np  <= 1'b0;
         raddr_np <= '0;
      end else begin
         rv_q_np <= req_np;
         if (req_np) raddr_np <= addr_np;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitors: every accepted request pops one expected address
   always @(negedge clk) begin
      if (req_pf && ready_en) begin
         xfer_cnt++;
         if (exp_pf.size() == 0) begin
            vecs++;
            fails++;
            $display("FAIL pf_req_unexpected: got addr %h expected no request", addr_pf);
         end else begin
            check("pf_req_addr", addr_pf, exp_pf.pop_front());
         end
      end
      if (valid_pf) check("pf_inst", inst_pf, pc_pf + 32'd1);
   end

   always @(negedge clk) begin
      if (req_np) begin
         if (exp_np.size() == 0) begin
            vecs++;
            fails++;
            $display("FAIL np_req_unexpected: got addr %h expected no request", addr_np);
         end else begin
            check("np_req_addr", addr_np, exp_np.pop_front());
         end
      end
      if (valid_np) check("np_inst", inst_np, pc_np + 32'd1);
   end

   initial begin
      rst = 1'b1; rst_np = 1'b1; pc_pf = '0; pc_np = '0;
      ready_en = 1'b1; rv_inj = 1'b0; err_en = 1'b0; err_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req", 32'(req_pf), 32'd0);
      check("rst_addr", addr_pf, 32'd0);
      check("rst_fault", 32'(fault_pf), 32'd0);
      check("rst_valid", 32'(valid_pf), 32'd0);
      check("rst_inst", inst_pf, 32'd0);

      // 1: cold fetch of word 0, then prefetch of 4
      @(posedge clk); #1;
      exp_pf.push_back(32'h0); exp_pf.push_back(32'h4);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t1_req_c1", 32'(req_pf), 32'd1);
      check("t1_addr_c1", addr_pf, 32'h0);
      @(negedge clk);
      check("t1_valid_c2", 32'(valid_pf), 32'd0);
      @(negedge clk);
      check("t1_valid_c3", 32'(valid_pf), 32'd1);
      check("t1_inst_c3", inst_pf, 32'h1);

      // 2: step to prefetched word, next request 8
      repeat (4) @(posedge clk); #1;
      pc_pf = 32'h4;
      exp_pf.push_back(32'h8);
      #1;
      check("t2_valid_step", 32'(valid_pf), 32'd1);
      check("t2_inst_step", inst_pf, 32'h5);
      @(posedge clk);
      @(negedge clk);
      check("t2_req", 32'(req_pf), 32'd1);
      check("t2_addr", addr_pf, 32'h8);

      // 3: redirect while word 8 is in flight
      @(posedge clk); #1;
      pc_pf = 32'h100;
      exp_pf.push_back(32'h100); exp_pf.push_back(32'h104);
      repeat (4) begin
         @(negedge clk);
         check("t3_valid_wait", 32'(valid_pf), 32'd0);
      end
      @(negedge clk);
      check("t3_valid", 32'(valid_pf), 32'd1);
      check("t3_inst", inst_pf, 32'h101);

      // 4: bus stalls three cycles
      repeat (6) @(posedge clk); #1;
      ready_en = 1'b0;
      pc_pf = 32'h200;
      exp_pf.push_back(32'h200); exp_pf.push_back(32'h204);
      xfer_base = xfer_cnt;
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         check("t4_req_held", 32'(req_pf), 32'd1);
         check("t4_addr_held", addr_pf, 32'h200);
      end
      @(posedge clk); #1;
      ready_en = 1'b1;
      repeat (8) @(posedge clk); #1;
      check("t4_xfers", 32'(xfer_cnt - xfer_base), 32'd2);
      check("t4_inst", inst_pf, 32'h201);

      // 5: bus error makes a sticky fault
      pc_pf = 32'h10; err_en = 1'b1; err_addr = 32'h10;
      exp_pf.push_back(32'h10);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t5_fault", 32'(fault_pf), 32'd1);
      check("t5_valid", 32'(valid_pf), 32'd0);
      check("t5_req", 32'(req_pf), 32'd0);
      repeat (5) @(negedge clk);
      check("t5_fault_sticky", 32'(fault_pf), 32'd1);
      check("t5_req_quiet", 32'(req_pf), 32'd0);
      @(posedge clk); #1;
      pc_pf = 32'h12;
      repeat (2) @(negedge clk);
      check("t5_fault_mis", 32'(fault_pf), 32'd1);
      check("t5_req_mis", 32'(req_pf), 32'd0);
      err_en = 1'b0;

      // 6: async reset in RESP, late rvalid ignored
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      pc_pf = 32'h300;
      exp_pf.push_back(32'h300);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("t6_req", 32'(req_pf), 32'd0);
      check("t6_addr", addr_pf, 32'd0);
      check("t6_fault", 32'(fault_pf), 32'd0);
      check("t6_valid", 32'(valid_pf), 32'd0);
      check("t6_inst", inst_pf, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ready_en = 1'b0;
      exp_pf.push_back(32'h300); exp_pf.push_back(32'h304);
      @(posedge clk); #1;
      rv_inj = 1'b1;
      @(posedge clk); #1;
      rv_inj = 1'b0;
      @(negedge clk);
      check("t6_late_valid", 32'(valid_pf), 32'd0);
      check("t6_late_req", 32'(req_pf), 32'd1);
      @(posedge clk); #1;
      ready_en = 1'b1;
      repeat (8) @(posedge clk); #1;
      check("t6_refetch_inst", inst_pf, 32'h301);
      check("t6_refetch_valid", 32'(valid_pf), 32'd1);

      // misaligned pc from a clean state
      pc_pf = 32'h302;
      @(posedge clk);
      @(negedge clk);
      check("mis_fault", 32'(fault_pf), 32'd1);
      check("mis_req", 32'(req_pf), 32'd0);
      check("mis_valid", 32'(valid_pf), 32'd0);
      repeat (3) @(negedge clk);
      check("mis_req_quiet", 32'(req_pf), 32'd0);

      // demand-only rerun of 1-2
      @(posedge clk); #1;
      rst_np = 1'b0;
      exp_np.push_back(32'h0);
      @(posedge clk);
      @(negedge clk);
      check("np_req_c1", 32'(req_np), 32'd1);
      check("np_addr_c1", addr_np, 32'h0);
      repeat (2) @(negedge clk);
      check("np_valid_c3", 32'(valid_np), 32'd1);
      check("np_inst_c3", inst_np, 32'h1);
      repeat (5) @(posedge clk); #1;
      pc_np = 32'h4;
      exp_np.push_back(32'h4);
      #1;
      check("np_valid_drop", 32'(valid_np), 32'd0);
      repeat (4) @(negedge clk);
      check("np_valid_back", 32'(valid_np), 32'd1);
      check("np_inst_4", inst_np, 32'h5);
      repeat (4) @(negedge clk);

      check("pf_queue_left", 32'(exp_pf.size()), 32'd0);
      check("np_queue_left", 32'(exp_np.size()), 32'd0);
      check("np_fault", 32'(fault_np), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
